// File: rtl/apb_reg_completer.sv
// apb_reg_completer: APB4 completer fronting a bank of 32-bit registers.
// Index NUM_REGS-1 is a read-only window onto status_in; all others are read/write.
// Transfers get WAIT_CYCLES wait states, byte-strobed writes and pslverr on illegal access.
// Optional feature macro: APB_PROT_CHECK_EN rejects unprivileged accesses (pprot[0]=0).
module apb_reg_completer #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       NUM_REGS    = 16,
   parameter int unsigned       WAIT_CYCLES = 1,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              psel,
   input  logic              penable,
   input  logic [ADDR_W-1:0] paddr,
   input  logic              pwrite,
   input  logic [2:0]        pprot,
   input  logic [31:0]       pwdata,
   input  logic [3:0]        pstrb,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   input  logic [31:0]       status_in,
   output logic              wr_pulse,
   output logic [7:0]        wr_index
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned IDX_W  = 8;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned WIDX_W = ADDR_W - 2;
   localparam int unsigned RIDX_W = $clog2(NUM_REGS);

   localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WAIT_CYCLES);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [ADDR_W-1:0]   addr_q;
   logic                write_q;
   logic [2:0]          prot_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   strb_q;

   logic [DATA_W-1:0]   regs [NUM_REGS];

   logic [ADDR_W-1:0]   offset;
   logic [WIDX_W-1:0]   word_idx;
   logic [IDX_W-1:0]    idx;
   logic [RIDX_W-1:0]   ridx;
   logic                in_range;
   logic                is_status;
   logic                prot_err;
   logic                access_err;
   logic [DATA_W-1:0]   rd_data;
   logic                latch_en;
   logic                commit;

   // Address decode works on the latched transfer, never on live bus inputs.
   assign offset     = addr_q - BASE_ADDR;
   assign word_idx   = offset[ADDR_W-1:2];
   assign in_range   = ADDR_W'(word_idx) < ADDR_W'(NUM_REGS);
   assign idx        = IDX_W'(word_idx);
   assign ridx       = RIDX_W'(word_idx);
   assign is_status  = in_range && (idx == STATUS_IDX);

`ifdef APB_PROT_CHECK_EN
   assign prot_err   = ~prot_q[0];
`else
   assign prot_err   = 1'b0;
   logic prot_unused;
   assign prot_unused = ^prot_q;
`endif

   assign access_err = (offset[1:0] != 2'b00) || !in_range || (write_q && is_status) || prot_err;
   assign rd_data    = is_status ? status_in : regs[ridx];

   // State register and wait counter.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and bus response; reset masks pready so an in-flight transfer never completes.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      latch_en = 1'b0;
      commit   = 1'b0;
      pready   = 1'b0;
      pslverr  = 1'b0;
      prdata   = '0;
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               latch_en = 1'b1;
               cnt_d    = '0;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               pready  = 1'b1;
               pslverr = access_err;
               commit  = write_q && !access_err;
               if (!write_q && !access_err) begin
                  prdata = rd_data;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (preset) begin
         latch_en = 1'b0;
         commit   = 1'b0;
         pready   = 1'b0;
         pslverr  = 1'b0;
         prdata   = '0;
      end
   end

   // Capture the setup-phase controls so mid-access input changes have no effect.
   always_ff @(posedge pclk) begin
      if (preset) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         prot_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else if (latch_en) begin
         addr_q  <= paddr;
         write_q <= pwrite;
         prot_q  <= pprot;
         wdata_q <= pwdata;
         strb_q  <= pstrb;
      end
   end

   // Register bank update with byte strobes, plus the write notification.
   always_ff @(posedge pclk) begin
      if (preset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         wr_pulse <= 1'b0;
         wr_index <= '0;
      end else begin
         wr_pulse <= commit;
         if (commit) begin
            wr_index <= idx;
            for (int b = 0; b < STRB_W; b++) begin
               if (strb_q[b]) begin
                  regs[ridx][8*b +: 8] <= wdata_q[8*b +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_reg_completer.sv
// tb_apb_reg_completer: scoreboard bench for apb_reg_completer (default parameters).
// Honours APB_PROT_CHECK_EN in its reference model when the macro is defined.
`timescale 1ns/1ps
module tb_apb_reg_completer;
   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned NUM_REGS    = 16;
   localparam int unsigned WAIT_CYCLES = 1;
   localparam int unsigned MIDX_W      = $clog2(NUM_REGS);

   logic              pclk = 1'b0;
   logic              preset;
   logic              psel;
   logic              penable;
   logic [ADDR_W-1:0] paddr;
   logic              pwrite;
   logic [2:0]        pprot;
   logic [31:0]       pwdata;
   logic [3:0]        pstrb;
   logic [31:0]       prdata;
   logic              pready;
   logic              pslverr;
   logic [31:0]       status_in;
   logic              wr_pulse;
   logic [7:0]        wr_index;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        pulse;
      logic [7:0]  index;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mregs [NUM_REGS];
   logic [7:0]  m_last_idx;
   logic        pend_pulse;
   int          n_cmp = 0;
   int          n_err = 0;

   apb_reg_completer #(
      .ADDR_W      (ADDR_W),
      .NUM_REGS    (NUM_REGS),
      .WAIT_CYCLES (WAIT_CYCLES),
      .BASE_ADDR   (32'h0)
   ) dut (
      .pclk      (pclk),
      .preset    (preset),
      .psel      (psel),
      .penable   (penable),
      .paddr     (paddr),
      .pwrite    (pwrite),
      .pprot     (pprot),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr),
      .status_in (status_in),
      .wr_pulse  (wr_pulse),
      .wr_index  (wr_index)
   );

   always #5 pclk = ~pclk;

   // Hard stop in case a wait loop is ever broken.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at the negedge one cycle after a completion edge.
   task automatic check_pulse();
      check_eq("wr_pulse", 32'(wr_pulse), 32'(pend_pulse));
      check_eq("wr_index", 32'(wr_index), 32'(m_last_idx));
      pend_pulse = 1'b0;
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic bus_idle();
      psel    = 1'b0;
      penable = 1'b0;
      @(negedge pclk);
      check_pulse();
      check_eq("idle_pready", 32'(pready), 32'h0);
      tick();
   endtask

   // One full transfer; optionally disturbs bus inputs during the access phase.
   task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot, input bit scramble);
      exp_t        e;
      int          waits;
      logic [31:0] offs;
      int unsigned idx;
      logic        err;
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = addr;
      pwrite  = wr;
      pwdata  = wdata;
      pstrb   = strb;
      pprot   = prot;
      @(negedge pclk);
      check_pulse();
      offs = addr - 32'h0;
      idx  = offs >> 2;
      err  = (offs[1:0] != 2'b00) || (idx >= NUM_REGS) || (wr && (idx == NUM_REGS - 1));
`ifdef APB_PROT_CHECK_EN
      if (!prot[0]) err = 1'b1;
`endif
      e.err   = err;
      e.rdata = '0;
      e.pulse = 1'b0;
      e.index = 8'(idx);
      if (!err && !wr) e.rdata = (idx == NUM_REGS - 1) ? status_in : mregs[MIDX_W'(idx)];
      if (!err && wr) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) mregs[MIDX_W'(idx)][8*b +: 8] = wdata[8*b +: 8];
         end
         e.pulse = 1'b1;
      end
      sb.push_back(e);
      tick();
      penable = 1'b1;
      if (scramble) begin
         paddr  = addr ^ 32'h4;
         pwdata = ~wdata;
         pstrb  = ~strb;
         pwrite = ~wr;
      end
      @(negedge pclk);
      waits = 0;
      while (!pready && waits < 16) begin
         tick();
         @(negedge pclk);
         waits++;
      end
      e = sb.pop_front();
      check_eq("latency", 32'(waits), 32'(WAIT_CYCLES));
      if (pready) begin
         check_eq("pslverr", 32'(pslverr), 32'(e.err));
         check_eq("prdata", prdata, e.rdata);
      end else begin
         check_eq("pready_timeout", 32'(pready), 32'h1);
      end
      if (e.pulse) begin
         pend_pulse = 1'b1;
         m_last_idx = e.index;
      end
      tick();
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   // Start a write, then kill it just before completion by dropping psel or asserting reset.
   task automatic abort_xfer(input logic [31:0] addr, input logic [31:0] wdata, input bit by_reset);
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = addr;
      pwrite  = 1'b1;
      pwdata  = wdata;
      pstrb   = 4'hF;
      pprot   = 3'b001;
      @(negedge pclk);
      check_pulse();
      tick();
      penable = 1'b1;
      @(negedge pclk);
      check_eq("abort_wait", 32'(pready), 32'h0);
      tick();
      if (by_reset) preset = 1'b1;
      else begin
         psel    = 1'b0;
         penable = 1'b0;
      end
      @(negedge pclk);
      check_eq("abort_pready", 32'(pready), 32'h0);
      tick();
      preset  = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      if (by_reset) begin
         for (int i = 0; i < NUM_REGS; i++) mregs[i] = '0;
         m_last_idx = '0;
      end
      @(negedge pclk);
      check_eq("abort_pulse", 32'(wr_pulse), 32'h0);
      check_eq("abort_index", 32'(wr_index), 32'(m_last_idx));
      tick();
   endtask

   initial begin
      logic [31:0] a;
      preset     = 1'b1;
      psel       = 1'b0;
      penable    = 1'b0;
      paddr      = '0;
      pwrite     = 1'b0;
      pprot      = 3'b001;
      pwdata     = '0;
      pstrb      = '0;
      status_in  = 32'h0;
      pend_pulse = 1'b0;
      m_last_idx = '0;
      for (int i = 0; i < NUM_REGS; i++) mregs[i] = '0;

      tick();
      tick();
      @(negedge pclk);
      check_eq("rst_pready", 32'(pready), 32'h0);
      check_eq("rst_pslverr", 32'(pslverr), 32'h0);
      check_eq("rst_prdata", prdata, 32'h0);
      check_eq("rst_wr_pulse", 32'(wr_pulse), 32'h0);
      check_eq("rst_wr_index", 32'(wr_index), 32'h0);
      tick();
      preset = 1'b0;
      bus_idle();

      // Full write, read back, then partial strobed write.
      apb_xfer(32'h08, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, 1'b0);
      bus_idle();
      apb_xfer(32'h08, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0);
      apb_xfer(32'h08, 1'b1, 32'h11223344, 4'b0101, 3'b001, 1'b0);
      apb_xfer(32'h08, 1'b0, 32'h0, 4'hF, 3'b001, 1'b0);
      check_eq("strobe_model", mregs[2], 32'hDE22BE44);

      // Illegal accesses: out of range, misaligned, write to status.
      apb_xfer(32'h40, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0);
      apb_xfer(32'h06, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0);
      apb_xfer(32'h3C, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, 1'b0);
      bus_idle();

      // Live status read.
      status_in = 32'hA5A5_0001;
      apb_xfer(32'h3C, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0);

      // Zero-strobe write still pulses but changes nothing.
      apb_xfer(32'h04, 1'b1, 32'h12345678, 4'hF, 3'b001, 1'b0);
      apb_xfer(32'h04, 1'b1, 32'hFFFFFFFF, 4'h0, 3'b001, 1'b0);
      apb_xfer(32'h04, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0);

      // Inputs disturbed mid-access must not affect the latched transfer.
      apb_xfer(32'h10, 1'b1, 32'hCAFEF00D, 4'hF, 3'b001, 1'b1);
      apb_xfer(32'h10, 1'b0, 32'h0, 4'h0, 3'b001, 1'b1);
      bus_idle();

      // penable without a setup phase is ignored.
      psel    = 1'b1;
      penable = 1'b1;
      paddr   = 32'h0;
      pwrite  = 1'b1;
      @(negedge pclk);
      check_pulse();
      check_eq("nosetup_pready0", 32'(pready), 32'h0);
      tick();
      @(negedge pclk);
      check_eq("nosetup_pready1", 32'(pready), 32'h0);
      tick();
      bus_idle();
      apb_xfer(32'h00, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0);

      // Abort by psel drop leaves the register untouched.
      abort_xfer(32'h08, 32'h0BAD0BAD, 1'b0);
      apb_xfer(32'h08, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0);

      // Protection attribute handling (error only when the check is compiled in).
      apb_xfer(32'h00, 1'b1, 32'h55AA55AA, 4'hF, 3'b000, 1'b0);
      apb_xfer(32'h00, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0);
      apb_xfer(32'h00, 1'b1, 32'h600DF00D, 4'hF, 3'b001, 1'b0);
      apb_xfer(32'h00, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0);

      // Random back-to-back mix of reads, writes and illegal addresses.
      for (int n = 0; n < 24; n++) begin
         a = 32'($urandom_range(0, 17)) << 2;
         if ($urandom_range(0, 7) == 0) a = a | 32'h2;
         apb_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 3'b001, 1'b0);
         if ($urandom_range(0, 3) == 0) bus_idle();
      end
      bus_idle();

      // Reset in the middle of a write: no completion, bank cleared.
      abort_xfer(32'h0C, 32'hFEEDFACE, 1'b1);
      apb_xfer(32'h0C, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0);
      apb_xfer(32'h08, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0);
      bus_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
